// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp
// Brief    : Two-write, NRD-read register file with optional write forwarding
//            and a ready/valid register dump stream.
// Revision : 1.0
// ============================================================================
module register_file_mp #(
    parameter int DW     = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              wen0,
    input  logic [AW-1:0]     wsel0,
    input  logic [DW-1:0]     wdat0,
    input  logic              wen1,
    input  logic [AW-1:0]     wsel1,
    input  logic [DW-1:0]     wdat1,
    input  logic [NRD*AW-1:0] rsel,
    output logic [NRD*DW-1:0] rdat,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [AW-1:0]     dump_idx,
    output logic [DW-1:0]     dump_dat,
    output logic              dump_busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_t;

    logic [DW-1:0] r_regs [NREGS];
    logic          w_we0;
    logic          w_we1;
    dump_state_t   r_state;
    dump_state_t   w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;

    // Index 0 is never written, so its reset value of 0 is permanent.
    assign w_we0 = wen0 && (wsel0 != '0);
    assign w_we1 = wen1 && (wsel1 != '0);

    // Port 1 is assigned last so it wins a same-index collision.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_we0) begin
                r_regs[wsel0] <= wdat0;
            end
            if (w_we1) begin
                r_regs[wsel1] <= wdat1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_sel;
        logic [DW-1:0] w_dat;

        assign w_sel = rsel[k*AW +: AW];

        always_comb begin
            w_dat = r_regs[w_sel];
            if (BYPASS != 0) begin
                if (w_we1 && (wsel1 == w_sel)) begin
                    w_dat = wdat1;
                end else if (w_we0 && (wsel0 == w_sel)) begin
                    w_dat = wdat0;
                end
            end
        end

        assign rdat[k*DW +: DW] = w_dat;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (dump_req) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = '0;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (r_idx == AW'(NREGS - 1)) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + AW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Dump beats show stored contents only; forwarding never applies here.
    assign dump_valid = (r_state == SEND);
    assign dump_busy  = (r_state == SEND);
    assign dump_idx   = r_idx;
    assign dump_dat   = (r_state == SEND) ? r_regs[r_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_mp
// Brief    : Self-checking bench for register_file_mp (forwarding and
//            non-forwarding builds side by side, dump stream scoreboard).
// Revision : 1.0
// ============================================================================
module tb_register_file_mp;

    localparam int DW    = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] dat;
    } beat_t;

    logic              clk = 1'b0;
    logic              nrst;
    logic              wen0, wen1;
    logic [AW-1:0]     wsel0, wsel1;
    logic [DW-1:0]     wdat0, wdat1;
    logic [NRD*AW-1:0] rsel;
    logic [NRD*DW-1:0] rdat_b, rdat_n;
    logic              dump_req, dump_ready;
    logic              valid_b, valid_n, busy_b, busy_n;
    logic [AW-1:0]     idx_b, idx_n;
    logic [DW-1:0]     dat_b, dat_n;

    logic [DW-1:0] model [NREGS];
    beat_t         sb[$];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    register_file_mp #(.DW(DW), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(1)) u_dut_byp (
        .CLK(clk), .nRST(nrst),
        .wen0(wen0), .wsel0(wsel0), .wdat0(wdat0),
        .wen1(wen1), .wsel1(wsel1), .wdat1(wdat1),
        .rsel(rsel), .rdat(rdat_b),
        .dump_req(dump_req), .dump_ready(dump_ready),
        .dump_valid(valid_b), .dump_idx(idx_b), .dump_dat(dat_b), .dump_busy(busy_b)
    );

    register_file_mp #(.DW(DW), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(0)) u_dut_nob (
        .CLK(clk), .nRST(nrst),
        .wen0(wen0), .wsel0(wsel0), .wdat0(wdat0),
        .wen1(wen1), .wsel1(wsel1), .wdat1(wdat1),
        .rsel(rsel), .rdat(rdat_n),
        .dump_req(dump_req), .dump_ready(dump_ready),
        .dump_valid(valid_n), .dump_idx(idx_n), .dump_dat(dat_n), .dump_busy(busy_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rsel = {AW'(a1), AW'(a0)};
    endtask

    task automatic check_reads(input string tag, input logic [DW-1:0] eb0, input logic [DW-1:0] eb1,
                               input logic [DW-1:0] en0, input logic [DW-1:0] en1);
        check({tag, "_byp_p0"}, rdat_b[0 +: DW],  eb0);
        check({tag, "_byp_p1"}, rdat_b[DW +: DW], eb1);
        check({tag, "_nob_p0"}, rdat_n[0 +: DW],  en0);
        check({tag, "_nob_p1"}, rdat_n[DW +: DW], en1);
    endtask

    // Apply the currently driven writes to the reference model (port 1 last).
    task automatic commit_model();
        if (wen0 && wsel0 != '0) model[wsel0] = wdat0;
        if (wen1 && wsel1 != '0) model[wsel1] = wdat1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, valid_b, 1'b0);
        check({tag, "_busy"},  busy_b,  1'b0);
        check({tag, "_idx"},   idx_b,   '0);
        check({tag, "_dat"},   dat_b,   '0);
        check({tag, "_valid_nob"}, valid_n, 1'b0);
    endtask

    task automatic check_beat(input string tag, input beat_t b);
        check({tag, "_idx"},     idx_b, b.idx);
        check({tag, "_dat"},     dat_b, b.dat);
        check({tag, "_idx_nob"}, idx_n, b.idx);
        check({tag, "_dat_nob"}, dat_n, b.dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    beats;
        int    budget;
        bit    rdy;
        beat_t b;

        for (int i = 0; i < NREGS; i++) model[i] = '0;
        nrst = 1'b0; dump_req = 1'b0; dump_ready = 1'b0; rsel = '0;
        wen0 = 1'b1; wsel0 = AW'(9); wdat0 = 32'hDEAD_BEEF;
        wen1 = 1'b0; wsel1 = '0;     wdat1 = '0;
        tick(); tick();
        settle();
        check_idle("reset");

        wen0 = 1'b0; nrst = 1'b1;
        set_rd(9, 0); settle();
        check_reads("rst_write_dropped", 0, 0, 0, 0);

        tick();
        wen0 = 1'b1; wsel0 = AW'(5); wdat0 = 32'hA5;
        commit_model(); tick();
        wen0 = 1'b0; set_rd(5, 0); settle();
        check_reads("wr5", 32'hA5, 0, 32'hA5, 0);

        tick();
        wen0 = 1'b1; wsel0 = AW'(7); wdat0 = 32'h11;
        wen1 = 1'b1; wsel1 = AW'(7); wdat1 = 32'h22;
        set_rd(7, 7); settle();
        check_reads("collide7_same", 32'h22, 32'h22, 0, 0);
        commit_model(); tick();
        wen0 = 1'b0; wen1 = 1'b0; settle();
        check_reads("collide7_after", 32'h22, 32'h22, 32'h22, 32'h22);

        tick();
        wen0 = 1'b1; wsel0 = '0; wdat0 = 32'hFFFF_FFFF;
        wen1 = 1'b1; wsel1 = '0; wdat1 = 32'hFFFF_FFFF;
        set_rd(0, 0); settle();
        check_reads("zero_same", 0, 0, 0, 0);
        commit_model(); tick();
        wen0 = 1'b0; wen1 = 1'b0; settle();
        check_reads("zero_after", 0, 0, 0, 0);

        tick();
        wen0 = 1'b1; wsel0 = AW'(3); wdat0 = 32'h55;
        set_rd(3, 5); settle();
        check_reads("fwd3_same", 32'h55, 32'hA5, 0, 32'hA5);
        commit_model(); tick();
        wen0 = 1'b0; settle();
        check_reads("fwd3_after", 32'h55, 32'hA5, 32'h55, 32'hA5);

        tick();
        wen0 = 1'b1; wsel0 = AW'(5); wdat0 = 32'h66;
        wen1 = 1'b1; wsel1 = AW'(3); wdat1 = 32'h77;
        set_rd(5, 3); settle();
        check_reads("fwd_split_same", 32'h66, 32'h77, 32'hA5, 32'h55);
        commit_model(); tick();
        wen0 = 1'b0; wen1 = 1'b0; settle();
        check_reads("fwd_split_after", 32'h66, 32'h77, 32'h66, 32'h77);

        // Load register i with i*3 two registers per cycle.
        for (int i = 1; i < NREGS; i += 2) begin
            wen0 = 1'b1; wsel0 = AW'(i); wdat0 = DW'(i * 3);
            wen1 = (i + 1 < NREGS); wsel1 = AW'(i + 1); wdat1 = DW'((i + 1) * 3);
            commit_model(); tick();
        end
        wen0 = 1'b0; wen1 = 1'b0;
        set_rd(31, 12); settle();
        check_reads("load", 32'd93, 32'd36, 32'd93, 32'd36);

        for (int i = 0; i < NREGS; i++) begin
            b.idx = AW'(i); b.dat = model[i];
            sb.push_back(b);
        end
        dump_req = 1'b1;
        tick();
        beats = 0; budget = 0; rdy = 1'b0;
        while (sb.size() > 0 && budget < 400) begin
            dump_ready = rdy; rdy = ~rdy;
            settle();
            check("dump_valid", valid_b, 1'b1);
            check("dump_busy",  busy_b,  1'b1);
            if (dump_ready) begin
                b = sb.pop_front();
                check_beat("beat", b);
                beats++;
            end else begin
                check_beat("hold", sb[0]);
            end
            tick();
            budget++;
        end
        check("dump_leftover", sb.size(), 0);
        check("dump_beats", beats, NREGS);

        // Back in IDLE for one cycle; held dump_req restarts on the next edge.
        dump_ready = 1'b0; settle();
        check_idle("post_dump");
        tick();
        dump_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b.idx = AW'(i); b.dat = model[i];
            sb.push_back(b);
        end
        dump_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            settle();
            check("redump_valid", valid_b, 1'b1);
            b = sb.pop_front();
            check_beat("redump", b);
            tick();
        end

        dump_ready = 1'b0; nrst = 1'b0;
        tick(); settle();
        check_idle("mid_dump_reset");
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        nrst = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            set_rd(i, NREGS - 1 - i); settle();
            check_reads("cleared", model[i], model[NREGS - 1 - i], model[i], model[NREGS - 1 - i]);
        end
        dump_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick(); settle();
            check("no_beats_after_abort", valid_b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DW, default 32: data width of every register, in bits.
REQ-002 Parameter NREGS, default 32: register count, power of two, minimum 4.
REQ-003 Parameter AW, default $clog2(NREGS): register index width.
REQ-004 Parameter NRD, default 2: number of read ports, range 1..4.
REQ-005 Parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-006 CLK  in  1  single clock; all state changes on its rising edge.
REQ-007 nRST  in  1  reset; synchronous and active-low.
REQ-008 wen0 / wsel0 / wdat0  in  1 / AW / DW  write port 0: enable, index, data.
REQ-009 wen1 / wsel1 / wdat1  in  1 / AW / DW  write port 1: enable, index, data.
REQ-010 rsel  in  NRD*AW  packed read indices; port k uses bits [k*AW +: AW].
REQ-011 rdat  out  NRD*DW  packed read data; port k uses bits [k*DW +: DW].
REQ-012 dump_req  in  1  request to stream all registers out in order.
REQ-013 dump_ready  in  1  consumer accepts the current dump beat.
REQ-014 dump_valid  out  1  dump beat present.
REQ-015 dump_idx  out  AW  index of the current dump beat.
REQ-016 dump_dat  out  DW  contents of register dump_idx.
REQ-017 dump_busy  out  1  dump state machine is not IDLE.

Function
REQ-018 Register 0 SHALL always read 0; writes to index 0 on either port SHALL be discarded.
REQ-019 A write with wenN=1 SHALL update register wselN at the next rising CLK edge.
REQ-020 If both ports write the same nonzero index in one cycle, port 1 data SHALL be stored.
REQ-021 Reads SHALL be combinational from rsel; every read port is independent.
REQ-022 BYPASS=1: a read index equal to an enabled nonzero write index in the same cycle SHALL return that write data, with port 1 taking priority over port 0.
REQ-023 BYPASS=0: same-cycle reads SHALL return the value stored before the edge.
REQ-024 The dump FSM SHALL have two states: IDLE and SEND.
REQ-025 IDLE -> SEND when dump_req=1; dump_idx SHALL be 0 on the first SEND cycle.
REQ-026 In SEND, dump_valid SHALL be 1 and dump_dat SHALL equal stored register dump_idx, with no bypass applied.
REQ-027 A beat transfers when dump_valid and dump_ready are both 1; dump_idx SHALL then increment by 1.
REQ-028 dump_valid, dump_idx and dump_dat SHALL hold stable while dump_ready=0.
REQ-029 Transfer of index NREGS-1 SHALL return the FSM to IDLE with dump_idx wrapped to 0; it SHALL NOT continue to index NREGS.
REQ-030 dump_req SHALL be ignored while in SEND.
REQ-031 dump_req held high SHALL start a new dump on the cycle after return to IDLE.
REQ-032 Writes SHALL proceed during a dump; a beat shows the register value current in its transfer cycle.
REQ-033 In IDLE, dump_valid SHALL be 0 and dump_dat SHALL be 0.
REQ-034 dump_busy SHALL be 1 exactly when the FSM state is SEND.

Reset
REQ-035 When nRST=0 at a CLK edge, all registers SHALL become 0 and the FSM SHALL enter IDLE.
REQ-036 When nRST=0 at a CLK edge, dump_valid, dump_busy, dump_idx and dump_dat SHALL become 0, and any write in that cycle SHALL be discarded.
REQ-037 Reset asserted mid-dump SHALL abort the dump; no further beats SHALL appear until a new dump_req.
REQ-038 rdat SHALL read 0 for every index after reset, except that the combinational bypass SHALL still forward when BYPASS=1.

Verification
REQ-039 Write wsel0=5, wdat0=0xA5 -> next cycle, rsel port0=5 reads 0xA5 and port1=0 reads 0.
REQ-040 wen0=wen1=1, both index 7, wdat0=0x11, wdat1=0x22 -> register 7 stores 0x22; with BYPASS=1 a same-cycle read of 7 returns 0x22.
REQ-041 Write index 0 with 0xFFFFFFFF -> every read of index 0 returns 0, including in the write cycle.
REQ-042 Load reg i=i*3, pulse dump_req, toggle dump_ready every other cycle -> exactly NREGS beats with idx 0..NREGS-1 and dat i*3; held beats stay stable; dump_busy falls after the last beat.
REQ-043 nRST=0 after 4 beats of a dump -> next cycle dump_valid=0, dump_busy=0, dump_idx=0, and all registers read 0.
REQ-044 BYPASS=0 build: write 0x55 to index 3 while reading 3 -> the read returns the old value 0 that cycle and 0x55 the next cycle.
